// File: rtl/alu_result_buffer.sv
// alu_result_buffer: two-entry valid/ready buffer carrying ALU results, tags and zero/neg flags to write-back
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_ZERO,
  output logic             OUT_NEG,
  output logic [1:0]       COUNT
);
  logic [WIDTH-1:0] data_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0] zero_q, neg_q;
  logic rd_ptr, wr_ptr, push, pop;
  logic [1:0] count_q;
  // handshake terms depend only on registered occupancy, never on OUT_READY for IN_READY
  always_comb begin
    IN_READY  = count_q != 2'd2;
    OUT_VALID = count_q != 2'd0;
    push      = IN_VALID & IN_READY;
    pop       = OUT_VALID & OUT_READY;
    COUNT     = count_q;
    OUT_DATA  = OUT_VALID ? data_q[rd_ptr] : '0;
    OUT_TAG   = OUT_VALID ? tag_q[rd_ptr] : '0;
    OUT_ZERO  = OUT_VALID ? zero_q[rd_ptr] : 1'b0;
    OUT_NEG   = OUT_VALID ? neg_q[rd_ptr] : 1'b0;
  end
  // reset clears storage too; flush only drops occupancy so squashed work never drains
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      data_q  <= '{default: '0};
      tag_q   <= '{default: '0};
      zero_q  <= '0;
      neg_q   <= '0;
    end else if (FLUSH) begin
      count_q <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= IN_DATA;
        tag_q[wr_ptr]  <= IN_TAG;
        zero_q[wr_ptr] <= IN_DATA == '0;
        neg_q[wr_ptr]  <= IN_DATA[WIDTH-1];
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [31:0] IN_DATA = '0;
  logic [4:0]  IN_TAG = '0;
  logic        IN_READY, OUT_VALID, OUT_ZERO, OUT_NEG;
  logic [31:0] OUT_DATA;
  logic [4:0]  OUT_TAG;
  logic [1:0]  COUNT;
  int checks = 0, failures = 0;

  alu_result_buffer #(.WIDTH(32), .TAG_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_TAG(IN_TAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_TAG(OUT_TAG), .OUT_ZERO(OUT_ZERO), .OUT_NEG(OUT_NEG), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] t);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_TAG   = t;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(IN_READY), 64'd1);
    chk({tag, "_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_data"}, 64'(OUT_DATA), 64'd0);
    chk({tag, "_tag"}, 64'(OUT_TAG), 64'd0);
    chk({tag, "_zero"}, 64'(OUT_ZERO), 64'd0);
    chk({tag, "_neg"}, 64'(OUT_NEG), 64'd0);
    chk({tag, "_count"}, 64'(COUNT), 64'd0);
  endtask

  initial begin
    tick();
    RESET = 1'b0;
    chk_idle("rst");

    push(32'h0000_00F0, 5'd3);
    chk("t1_valid", 64'(OUT_VALID), 64'd1);
    chk("t1_data", 64'(OUT_DATA), 64'h0000_00F0);
    chk("t1_tag", 64'(OUT_TAG), 64'd3);
    chk("t1_zero", 64'(OUT_ZERO), 64'd0);
    chk("t1_neg", 64'(OUT_NEG), 64'd0);
    chk("t1_count", 64'(COUNT), 64'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("t1_drain", 64'(COUNT), 64'd0);

    push(32'h8000_0000, 5'd1);
    push(32'h0, 5'd2);
    chk("t2_count", 64'(COUNT), 64'd2);
    chk("t2_ready", 64'(IN_READY), 64'd0);
    chk("t2_head", 64'(OUT_DATA), 64'h8000_0000);
    chk("t2_neg", 64'(OUT_NEG), 64'd1);
    chk("t2_htag", 64'(OUT_TAG), 64'd1);
    push(32'h1, 5'd4);
    chk("t2_rej_count", 64'(COUNT), 64'd2);
    chk("t2_rej_tag", 64'(OUT_TAG), 64'd1);
    OUT_READY = 1'b1;
    tick();
    chk("t2_pop1_tag", 64'(OUT_TAG), 64'd2);
    chk("t2_pop1_zero", 64'(OUT_ZERO), 64'd1);
    chk("t2_pop1_neg", 64'(OUT_NEG), 64'd0);
    chk("t2_pop1_count", 64'(COUNT), 64'd1);
    tick();
    OUT_READY = 1'b0;
    chk_idle("t2_empty");

    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(32'(i), 5'(i + 8));
      chk($sformatf("t3_data%0d", i), 64'(OUT_DATA), 64'(i));
      chk($sformatf("t3_tag%0d", i), 64'(OUT_TAG), 64'(i + 8));
      chk($sformatf("t3_count%0d", i), 64'(COUNT), 64'd1);
      chk($sformatf("t3_ready%0d", i), 64'(IN_READY), 64'd1);
      IN_VALID = (i < 7);
    end
    tick();
    chk("t3_end_count", 64'(COUNT), 64'd0);
    OUT_READY = 1'b0;

    push(32'd10, 5'd10);
    push(32'd11, 5'd11);
    chk("t4_full", 64'(COUNT), 64'd2);
    OUT_READY = 1'b1;
    push(32'd12, 5'd12);
    chk("t4_count", 64'(COUNT), 64'd1);
    chk("t4_tag", 64'(OUT_TAG), 64'd11);
    chk("t4_data", 64'(OUT_DATA), 64'd11);
    tick();
    OUT_READY = 1'b0;
    chk("t4_nopush", 64'(COUNT), 64'd0);

    push(32'd20, 5'd20);
    push(32'd21, 5'd21);
    chk("t5_full", 64'(COUNT), 64'd2);
    FLUSH = 1'b1;
    push(32'd22, 5'd22);
    FLUSH = 1'b0;
    chk_idle("t5_flush");
    push(32'hA5A5_A5A5, 5'd7);
    chk("t5_data", 64'(OUT_DATA), 64'hA5A5_A5A5);
    chk("t5_tag", 64'(OUT_TAG), 64'd7);
    chk("t5_neg", 64'(OUT_NEG), 64'd1);
    chk("t5_count", 64'(COUNT), 64'd1);

    RESET = 1'b1;
    FLUSH = 1'b1;
    push(32'h55, 5'd9);
    RESET = 1'b0;
    FLUSH = 1'b0;
    chk_idle("t6_rst");
    tick();
    chk("t6_lost", 64'(COUNT), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Two-entry registered buffer between the execute-stage logic units (OR32/AND32 outputs, muxed by the ALU) and the write-back stage of the extended DLX.
- Decouples execute from write-back with a valid/ready handshake.
- Attaches zero and sign flags to each result at capture time.
- Sustains one result per cycle when write-back is not stalling.

Parameters:
- WIDTH, 32, data width of the ALU result.
- TAG_W, 5, width of the destination-register tag carried with each result.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous discard of all buffered entries (branch squash).
- IN_VALID  input  1  execute stage presents a result.
- IN_READY  output  1  buffer can accept a result this cycle.
- IN_DATA  input  WIDTH  ALU result (e.g. OR32 O output).
- IN_TAG  input  TAG_W  destination register index.
- OUT_VALID  output  1  head entry is valid.
- OUT_READY  input  1  write-back consumes the head entry this cycle.
- OUT_DATA  output  WIDTH  head result.
- OUT_TAG  output  TAG_W  head destination tag.
- OUT_ZERO  output  1  head result == 0.
- OUT_NEG  output  1  head result bit WIDTH-1.
- COUNT  output  2  number of valid entries (0..2).

Behaviour:
- Storage: two entries (data, tag, zero, neg), circular, 1-bit rd/wr pointers plus a 2-bit count register.
- Push = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY. Both are evaluated on the same edge.
- IN_READY = (COUNT != 2). Depends on registered state only; no combinational path from OUT_READY.
- OUT_VALID = (COUNT != 0).
- OUT_DATA, OUT_TAG, OUT_ZERO and OUT_NEG come from the entry at the rd pointer. All four are forced to 0 while COUNT == 0.
- Flags are computed from IN_DATA at push and stored with the entry. They are never recomputed.
- Latency: a push on edge k makes OUT_VALID = 1 in the cycle after edge k (1-cycle latency).
- Throughput: with OUT_READY held at 1, one result per cycle; COUNT stays at 1 once the stream starts.
- Count 0: push only → 1. Pop impossible.
- Count 1, push + pop on the same edge: head advances to the new entry; COUNT stays 1.
- Count 2: IN_READY = 0, so IN_VALID is ignored. Pop → COUNT 1.
- Pointers wrap modulo 2.
- Ordering: strict FIFO; tags leave in arrival order.
- FLUSH = 1 on an edge:
  - COUNT ← 0 and both pointers ← 0.
  - Any push and pop in that cycle are discarded.
  - OUT_VALID = 0 in the following cycle.
- RESET = 1 on an edge:
  - COUNT ← 0, pointers ← 0, and storage data/tag/flags ← 0.
  - Takes priority over FLUSH and over any push or pop.
  - Reset mid-stream drops all entries. IN_READY = 1 in the first cycle after reset.
- Reset values: IN_READY = 1, OUT_VALID = 0, OUT_DATA = 0, OUT_TAG = 0, OUT_ZERO = 0, OUT_NEG = 0, COUNT = 0.
- No X propagation: OUT_* must not show stale storage when COUNT == 0.

Test Plan:
1. Reset, then push IN_DATA = 32'h0000_00F0, TAG = 3 with OUT_READY = 0 → next cycle OUT_VALID = 1, OUT_DATA = 32'h0000_00F0, OUT_TAG = 3, OUT_ZERO = 0, OUT_NEG = 0, COUNT = 1.
2. OUT_READY = 0; push 32'h8000_0000 (tag 1), then 32'h0 (tag 2), then attempt 32'h1 (tag 4) →
   - COUNT = 2 and IN_READY = 0; third push rejected.
   - Head shows 32'h8000_0000 with NEG = 1.
   - After two pops: tag 2, ZERO = 1; then COUNT = 0 and all OUT_* = 0.
3. OUT_READY = 1; stream 8 pushes on consecutive cycles, data = 0..7 → outputs 0..7 on consecutive cycles, each 1 cycle after its push, COUNT constant at 1, IN_READY never drops.
4. COUNT = 2, assert IN_VALID and OUT_READY on the same edge → exactly one pop and no push; COUNT = 1; the new head is the second entry.
5. COUNT = 2, assert FLUSH with IN_VALID = 1 → next cycle COUNT = 0, OUT_VALID = 0, IN_READY = 1. The subsequent push of 32'hA5A5_A5A5 appears as head.
6. COUNT = 1, assert RESET and FLUSH together with a push → next cycle all outputs are at reset values and the pushed data is lost.
